// File: rtl/line_fill_unit_if.sv
// Cache-side request/line signals and instruction-bus request/response
// signals of the line fill unit, grouped so the unit has a single bundle port.
interface line_fill_unit_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
);
  // cache side
  logic                                 fill_req;
  logic [BUS_DATA_WIDTH-1:0]            fill_addr;
  logic                                 fill_ready;
  logic                                 fill_done;
  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] fill_line;
  logic [BUS_DATA_WIDTH-1:0]            fill_line_addr;
  // instruction bus side
  logic [BUS_DATA_WIDTH-1:0]            bus_req;
  logic                                 bus_reqcyc;
  logic [BUS_TAG_WIDTH-1:0]             bus_reqtag;
  logic                                 bus_reqack;
  logic                                 bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0]            bus_resp;
  logic [BUS_TAG_WIDTH-1:0]             bus_resptag;
  logic                                 bus_respack;

  // the fill unit: accepts fills from the cache, initiates bus reads
  modport master (
    input  fill_req, fill_addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    output fill_ready, fill_done, fill_line, fill_line_addr,
           bus_req, bus_reqcyc, bus_reqtag, bus_respack
  );

  // the environment: cache plus arbiter/memory
  modport slave (
    output fill_req, fill_addr, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
    input  fill_ready, fill_done, fill_line, fill_line_addr,
           bus_req, bus_reqcyc, bus_reqtag, bus_respack
  );
endinterface

// File: rtl/line_fill_unit.sv
// Instruction-side line fill unit: takes one cache-line miss, issues a single
// tagged read on the instruction bus, gathers LINE_BEATS response beats and
// hands the assembled line back with a one-cycle done pulse.
module line_fill_unit #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       LINE_BEATS     = 8,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h1100
) (
  input  logic           clk,
  input  logic           reset,
  line_fill_unit_if.master lf
);

  localparam int LINE_BITS  = BUS_DATA_WIDTH * LINE_BEATS;
  localparam int LINE_BYTES = (BUS_DATA_WIDTH / 8) * LINE_BEATS;
  localparam int CNT_W      = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [BUS_DATA_WIDTH-1:0] OFFS_MASK = BUS_DATA_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [BUS_DATA_WIDTH-1:0] r_addr;
  logic [BUS_DATA_WIDTH-1:0] r_line_addr;
  logic [LINE_BITS-1:0]      r_buf;
  logic [LINE_BITS-1:0]      r_line;
  logic [LINE_BITS-1:0]      w_buf_nxt;
  logic                      w_accept;
  logic                      w_reqack;
  logic                      w_beat;
  logic                      w_last;

  assign w_accept = (r_state == ST_IDLE) && lf.fill_req;
  assign w_reqack = (r_state == ST_REQ) && lf.bus_reqack;
  // only our own tag is consumed; other tags belong to the data side
  assign w_beat   = (r_state == ST_RESP) && lf.bus_respcyc && (lf.bus_resptag == READ_TAG);
  assign w_last   = w_beat && (r_cnt == LAST_BEAT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the single outstanding fill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_REQ;
        else          w_state_nxt = ST_IDLE;
      end
      ST_REQ: begin
        if (w_reqack) w_state_nxt = ST_RESP;
        else          w_state_nxt = ST_REQ;
      end
      ST_RESP: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RESP;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Working line with the current beat dropped into its slot.
  always_comb begin
    w_buf_nxt = r_buf;
    w_buf_nxt[int'(r_cnt) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = lf.bus_resp;
  end

  // Address latch, beat counter, working buffer and the published line.
  // The published line is only replaced on the last beat so the cache sees
  // the previous line unchanged while a new fill is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_buf       <= '0;
      r_line      <= '0;
      r_line_addr <= '0;
    end else begin
      if (w_accept) r_addr <= lf.fill_addr & ~OFFS_MASK;
      if (w_reqack || w_last) r_cnt <= '0;
      else if (w_beat)        r_cnt <= r_cnt + CNT_W'(1);
      if (w_beat) r_buf <= w_buf_nxt;
      if (w_last) begin
        r_line      <= w_buf_nxt;
        r_line_addr <= r_addr;
      end
    end
  end

  assign lf.fill_ready     = (r_state == ST_IDLE);
  assign lf.fill_done      = (r_state == ST_DONE);
  assign lf.fill_line      = r_line;
  assign lf.fill_line_addr = r_line_addr;
  assign lf.bus_reqcyc     = (r_state == ST_REQ);
  assign lf.bus_req        = (r_state == ST_REQ) ? r_addr : '0;
  assign lf.bus_reqtag     = (r_state == ST_REQ) ? READ_TAG : '0;
  assign lf.bus_respack    = w_beat;

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: a bus/cache driver task feeds fills,
// a scoreboard queue holds the expected line and address of every fill.
module tb_line_fill_unit;

  localparam logic [12:0] RT = 13'h1100;
  localparam logic [12:0] FT = 13'h0100;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   done_seen;

  line_fill_unit_if ifc ();

  line_fill_unit dut (
    .clk   (clk),
    .reset (reset),
    .lf    (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counts every cycle in which fill_done is seen high
  always @(negedge clk) begin
    #2;
    if (ifc.fill_done === 1'b1) done_seen++;
  end

  // scoreboard
  logic [511:0] exp_line_q[$];
  logic [63:0]  exp_addr_q[$];

  // observations recorded by the driver
  int           obs_wait, obs_req_bad, obs_early_ack, obs_ack_miss, obs_foreign_ack, obs_ready_bad;
  logic         obs_reqcyc_first, obs_reqcyc_after, obs_done_now;
  logic [63:0]  obs_req_seen, obs_addr;
  logic [511:0] obs_line, obs_post_line;
  logic         obs_post_reqcyc, obs_post_respack, obs_post_ready;

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
    return l;
  endfunction

  // Drives one fill: request, reqack after ack_delay REQ cycles, 8 beats
  // (optional gaps, a foreign-tag beat before beat 4, beats during REQ),
  // optionally a reset after abort_after beats. Returns at the DONE negedge.
  task automatic drive_fill(input logic [63:0] addr, input logic [63:0] base, input int ack_delay,
                            input int max_gap, input bit foreign, input bit early,
                            input bit hold_req, input int abort_after);
    logic [63:0] al;
    int gap;
    al = addr & ~64'h3F;
    obs_wait = 0; obs_req_bad = 0; obs_early_ack = 0; obs_ack_miss = 0;
    obs_foreign_ack = 0; obs_ready_bad = 0; obs_done_now = 1'b0;
    @(negedge clk);
    ifc.fill_req = 1'b1; ifc.fill_addr = addr;
    #1;
    while (ifc.fill_ready !== 1'b1 && obs_wait < 50) begin
      @(negedge clk); #1; obs_wait++;
    end
    if (abort_after >= 8) begin
      exp_line_q.push_back(mk_line(base));
      exp_addr_q.push_back(al);
    end
    @(negedge clk);
    if (!hold_req) ifc.fill_req = 1'b0;
    #1;
    obs_reqcyc_first = ifc.bus_reqcyc;
    obs_req_seen     = ifc.bus_req;
    for (int k = 0; k <= ack_delay; k++) begin
      if (k == ack_delay) ifc.bus_reqack = 1'b1;
      if (early && k < ack_delay) begin
        ifc.bus_respcyc = 1'b1; ifc.bus_resptag = RT; ifc.bus_resp = 64'hBAD0;
      end
      #1;
      if (ifc.bus_reqcyc !== 1'b1 || ifc.bus_req !== al || ifc.bus_reqtag !== RT || ifc.fill_ready !== 1'b0)
        obs_req_bad++;
      if (early && k < ack_delay && ifc.bus_respack !== 1'b0) obs_early_ack++;
      @(negedge clk);
      ifc.bus_respcyc = 1'b0;
    end
    ifc.bus_reqack = 1'b0;
    #1;
    obs_reqcyc_after = ifc.bus_reqcyc;
    for (int i = 0; i < 8; i++) begin
      if (i == abort_after) break;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
      for (int g = 0; g < gap; g++) begin
        ifc.bus_respcyc = 1'b0; #1;
        if (ifc.fill_done !== 1'b0 || ifc.fill_ready !== 1'b0) obs_ready_bad++;
        @(negedge clk);
      end
      if (foreign && i == 4) begin
        ifc.bus_respcyc = 1'b1; ifc.bus_resptag = FT; ifc.bus_resp = 64'hDEADBEEF; #1;
        if (ifc.bus_respack !== 1'b0) obs_foreign_ack++;
        @(negedge clk);
      end
      ifc.bus_respcyc = 1'b1; ifc.bus_resptag = RT; ifc.bus_resp = base + 64'(i); #1;
      if (ifc.bus_respack !== 1'b1) obs_ack_miss++;
      if (ifc.fill_ready !== 1'b0 || ifc.fill_done !== 1'b0) obs_ready_bad++;
      @(negedge clk);
    end
    ifc.bus_respcyc = 1'b0;
    if (abort_after < 8) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ifc.bus_respcyc = 1'b1; ifc.bus_resptag = RT; #1;
      obs_post_reqcyc  = ifc.bus_reqcyc;
      obs_post_respack = ifc.bus_respack;
      obs_post_ready   = ifc.fill_ready;
      obs_post_line    = ifc.fill_line;
      ifc.bus_respcyc  = 1'b0;
    end else begin
      #1;
      obs_done_now = ifc.fill_done;
      obs_line     = ifc.fill_line;
      obs_addr     = ifc.fill_line_addr;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    ifc.bus_respcyc = 1'b1; ifc.bus_resptag = RT; #1;
    checks++; if (ifc.fill_ready !== 1'b1) begin errors++; $display("FAIL rst_fill_ready: got %b want 1", ifc.fill_ready); end
    checks++; if (ifc.fill_done !== 1'b0) begin errors++; $display("FAIL rst_fill_done: got %b want 0", ifc.fill_done); end
    checks++; if (ifc.bus_reqcyc !== 1'b0) begin errors++; $display("FAIL rst_reqcyc: got %b want 0", ifc.bus_reqcyc); end
    checks++; if (ifc.bus_req !== 64'h0) begin errors++; $display("FAIL rst_bus_req: got %h want 0", ifc.bus_req); end
    checks++; if (ifc.bus_reqtag !== 13'h0) begin errors++; $display("FAIL rst_reqtag: got %h want 0", ifc.bus_reqtag); end
    checks++; if (ifc.bus_respack !== 1'b0) begin errors++; $display("FAIL rst_respack: got %b want 0", ifc.bus_respack); end
    checks++; if (ifc.fill_line !== 512'h0) begin errors++; $display("FAIL rst_fill_line: got %h want 0", ifc.fill_line); end
    checks++; if (ifc.fill_line_addr !== 64'h0) begin errors++; $display("FAIL rst_line_addr: got %h want 0", ifc.fill_line_addr); end
    ifc.bus_respcyc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int d0;
    logic [511:0] el;
    logic [63:0]  ea;
    d0 = done_seen;
    drive_fill(64'h1234, 64'h100, 2, 0, 1'b0, 1'b0, 1'b0, 8);
    el = exp_line_q.pop_front(); ea = exp_addr_q.pop_front();
    checks++; if (obs_wait !== 0) begin errors++; $display("FAIL basic_accept_wait: got %0d want 0", obs_wait); end
    checks++; if (obs_reqcyc_first !== 1'b1) begin errors++; $display("FAIL basic_reqcyc_latency: got %b want 1", obs_reqcyc_first); end
    checks++; if (obs_req_seen !== 64'h1200) begin errors++; $display("FAIL basic_bus_req: got %h want 1200", obs_req_seen); end
    checks++; if (obs_req_bad !== 0) begin errors++; $display("FAIL basic_req_hold: got %0d bad cycles want 0", obs_req_bad); end
    checks++; if (obs_reqcyc_after !== 1'b0) begin errors++; $display("FAIL basic_reqcyc_drop: got %b want 0", obs_reqcyc_after); end
    checks++; if (obs_ack_miss !== 0) begin errors++; $display("FAIL basic_respack: got %0d missed want 0", obs_ack_miss); end
    checks++; if (obs_done_now !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", obs_done_now); end
    checks++; if (obs_line[63:0] !== 64'h100) begin errors++; $display("FAIL basic_beat0: got %h want 100", obs_line[63:0]); end
    checks++; if (obs_line[511:448] !== 64'h107) begin errors++; $display("FAIL basic_beat7: got %h want 107", obs_line[511:448]); end
    checks++; if (obs_line !== el) begin errors++; $display("FAIL basic_line: got %h want %h", obs_line, el); end
    checks++; if (obs_addr !== ea) begin errors++; $display("FAIL basic_line_addr: got %h want %h", obs_addr, ea); end
    @(negedge clk); #1;
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_seen - d0); end
    checks++; if (ifc.fill_line !== el) begin errors++; $display("FAIL basic_line_hold: got %h want %h", ifc.fill_line, el); end
    checks++; if (ifc.fill_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b want 1", ifc.fill_ready); end
  endtask

  task automatic test_gapped();
    int d0;
    logic [511:0] el;
    logic [63:0]  ea;
    d0 = done_seen;
    drive_fill(64'h1234, 64'h100, 2, 3, 1'b0, 1'b0, 1'b0, 8);
    el = exp_line_q.pop_front(); ea = exp_addr_q.pop_front();
    checks++; if (obs_ack_miss !== 0) begin errors++; $display("FAIL gap_respack: got %0d missed want 0", obs_ack_miss); end
    checks++; if (obs_ready_bad !== 0) begin errors++; $display("FAIL gap_early_done: got %0d bad cycles want 0", obs_ready_bad); end
    checks++; if (obs_done_now !== 1'b1) begin errors++; $display("FAIL gap_done_latency: got %b want 1", obs_done_now); end
    checks++; if (obs_line !== el) begin errors++; $display("FAIL gap_line: got %h want %h", obs_line, el); end
    checks++; if (obs_addr !== ea) begin errors++; $display("FAIL gap_line_addr: got %h want %h", obs_addr, ea); end
    @(negedge clk); #1;
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL gap_done_pulses: got %0d want 1", done_seen - d0); end
  endtask

  task automatic test_foreign_tag();
    logic [511:0] el;
    logic [63:0]  ea;
    drive_fill(64'h1234, 64'h100, 2, 0, 1'b1, 1'b0, 1'b0, 8);
    el = exp_line_q.pop_front(); ea = exp_addr_q.pop_front();
    checks++; if (obs_foreign_ack !== 0) begin errors++; $display("FAIL foreign_respack: got %0d acks want 0", obs_foreign_ack); end
    checks++; if (obs_ack_miss !== 0) begin errors++; $display("FAIL foreign_own_respack: got %0d missed want 0", obs_ack_miss); end
    checks++; if (obs_done_now !== 1'b1) begin errors++; $display("FAIL foreign_done: got %b want 1", obs_done_now); end
    checks++; if (obs_line !== el) begin errors++; $display("FAIL foreign_line: got %h want %h", obs_line, el); end
    checks++; if (obs_addr !== ea) begin errors++; $display("FAIL foreign_line_addr: got %h want %h", obs_addr, ea); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [511:0] el;
    logic [63:0]  ea;
    drive_fill(64'h40, 64'h200, 1, 0, 1'b0, 1'b0, 1'b1, 8);
    el = exp_line_q.pop_front(); ea = exp_addr_q.pop_front();
    checks++; if (obs_ready_bad !== 0 || obs_req_bad !== 0) begin errors++; $display("FAIL b2b_ready_low: got %0d/%0d bad cycles want 0", obs_ready_bad, obs_req_bad); end
    checks++; if (obs_done_now !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", obs_done_now); end
    checks++; if (obs_line !== el) begin errors++; $display("FAIL b2b_first_line: got %h want %h", obs_line, el); end
    checks++; if (obs_addr !== 64'h40) begin errors++; $display("FAIL b2b_first_addr: got %h want 40", obs_addr); end
    ifc.fill_addr = 64'h80;
    drive_fill(64'h80, 64'h300, 1, 0, 1'b0, 1'b0, 1'b0, 8);
    el = exp_line_q.pop_front(); ea = exp_addr_q.pop_front();
    checks++; if (obs_wait !== 0) begin errors++; $display("FAIL b2b_restart_wait: got %0d want 0", obs_wait); end
    checks++; if (obs_reqcyc_first !== 1'b1) begin errors++; $display("FAIL b2b_second_reqcyc: got %b want 1", obs_reqcyc_first); end
    checks++; if (obs_req_seen !== 64'h80) begin errors++; $display("FAIL b2b_second_bus_req: got %h want 80", obs_req_seen); end
    checks++; if (obs_line !== el) begin errors++; $display("FAIL b2b_second_line: got %h want %h", obs_line, el); end
    checks++; if (obs_addr !== ea) begin errors++; $display("FAIL b2b_second_addr: got %h want %h", obs_addr, ea); end
    @(negedge clk);
  endtask

  task automatic test_request_hold();
    logic [511:0] el;
    logic [63:0]  ea;
    drive_fill(64'h3ABC, 64'h400, 10, 0, 1'b0, 1'b1, 1'b0, 8);
    el = exp_line_q.pop_front(); ea = exp_addr_q.pop_front();
    checks++; if (obs_req_bad !== 0) begin errors++; $display("FAIL hold_req_stable: got %0d bad cycles want 0", obs_req_bad); end
    checks++; if (obs_early_ack !== 0) begin errors++; $display("FAIL hold_early_respack: got %0d acks want 0", obs_early_ack); end
    checks++; if (obs_req_seen !== 64'h3A80) begin errors++; $display("FAIL hold_bus_req: got %h want 3a80", obs_req_seen); end
    checks++; if (obs_line !== el) begin errors++; $display("FAIL hold_line: got %h want %h", obs_line, el); end
    checks++; if (obs_addr !== ea) begin errors++; $display("FAIL hold_line_addr: got %h want %h", obs_addr, ea); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill();
    int d0;
    logic [511:0] el;
    logic [63:0]  ea;
    d0 = done_seen;
    drive_fill(64'h5000, 64'h500, 2, 0, 1'b0, 1'b0, 1'b0, 4);
    checks++; if (obs_post_reqcyc !== 1'b0) begin errors++; $display("FAIL abort_reqcyc: got %b want 0", obs_post_reqcyc); end
    checks++; if (obs_post_respack !== 1'b0) begin errors++; $display("FAIL abort_respack: got %b want 0", obs_post_respack); end
    checks++; if (obs_post_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", obs_post_ready); end
    checks++; if (obs_post_line !== 512'h0) begin errors++; $display("FAIL abort_line_cleared: got %h want 0", obs_post_line); end
    checks++; if (done_seen - d0 !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_seen - d0); end
    drive_fill(64'h2000, 64'h600, 2, 0, 1'b0, 1'b0, 1'b0, 8);
    el = exp_line_q.pop_front(); ea = exp_addr_q.pop_front();
    checks++; if (obs_done_now !== 1'b1) begin errors++; $display("FAIL refill_done: got %b want 1", obs_done_now); end
    checks++; if (obs_line !== el) begin errors++; $display("FAIL refill_line: got %h want %h", obs_line, el); end
    checks++; if (obs_addr !== 64'h2000) begin errors++; $display("FAIL refill_addr: got %h want 2000", obs_addr); end
    @(negedge clk); #1;
    checks++; if (done_seen - d0 !== 1) begin errors++; $display("FAIL refill_done_pulses: got %0d want 1", done_seen - d0); end
  endtask

  initial begin
    checks = 0; errors = 0; done_seen = 0;
    reset = 1'b1;
    ifc.fill_req = 1'b0; ifc.fill_addr = 64'h0;
    ifc.bus_reqack = 1'b0; ifc.bus_respcyc = 1'b0;
    ifc.bus_resp = 64'h0; ifc.bus_resptag = 13'h0;
    test_reset();
    test_basic();
    test_gapped();
    test_foreign_tag();
    test_back_to_back();
    test_request_hold();
    test_reset_mid_fill();
    checks++; if (exp_line_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_line_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_fill_unit.md
Name: line_fill_unit

Overview:
- Upstream requester on the instruction side of the bus arbiter.
- Takes a single cache-line miss request from the fetch/I-cache, issues one read on the ibus_* side of the arbiter, and collects LINE_BEATS response beats into a full line.
- Returns the assembled line to the cache with a one-cycle done pulse.
- Supports one outstanding fill at a time.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus request/response data word.
- BUS_TAG_WIDTH, 13, width of bus request/response tag.
- LINE_BEATS, 8, response beats per line (power of two, 2..16).
- READ_TAG, 13'h1100, tag driven on read requests; responses are accepted only with this tag.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fill_req  in  1  cache requests a line fill; sampled only when fill_ready=1.
- fill_addr  in  BUS_DATA_WIDTH  miss address; any byte within the line.
- fill_ready  out  1  high in IDLE only; the fill unit can accept a request.
- fill_done  out  1  one-cycle pulse; fill_line and fill_line_addr valid.
- fill_line  out  BUS_DATA_WIDTH*LINE_BEATS  assembled line, beat i at bits [64i+63:64i].
- fill_line_addr  out  BUS_DATA_WIDTH  line-aligned address of fill_line.
- bus_req  out  BUS_DATA_WIDTH  read address to arbiter (ibus_req).
- bus_reqcyc  out  1  request valid (ibus_reqcyc).
- bus_reqtag  out  BUS_TAG_WIDTH  request tag (ibus_reqtag).
- bus_reqack  in  1  memory accepted request.
- bus_respcyc  in  1  response beat valid (ibus_respcyc).
- bus_resp  in  BUS_DATA_WIDTH  response data (ibus_resp).
- bus_resptag  in  BUS_TAG_WIDTH  response tag (ibus_resptag).
- bus_respack  out  1  beat consumed (ibus_respack).

Behaviour:
- Reset values:
  - state=IDLE, beat counter=0.
  - fill_ready=1, fill_done=0.
  - bus_reqcyc=0, bus_req=0, bus_reqtag=0, bus_respack=0.
  - fill_line=0, fill_line_addr=0.
- Line alignment: the line size is BUS_DATA_WIDTH/8*LINE_BEATS bytes (64 by default). The aligned address is fill_addr with its low log2(line bytes) bits cleared (bits [5:0] by default).
- IDLE:
  - fill_ready=1.
  - On fill_req=1, latch the aligned address and go to REQ.
  - Latency: fill_req accepted at edge N, bus_reqcyc high in cycle N+1.
- REQ:
  - bus_reqcyc=1, bus_req=latched aligned address, bus_reqtag=READ_TAG.
  - All three are held stable until bus_reqack is sampled high.
  - On bus_reqack=1, go to RESP with beat counter=0. bus_reqcyc drops the next cycle.
  - bus_reqack is ignored in any other state.
- RESP:
  - bus_respack is combinational: bus_respack = bus_respcyc && (bus_resptag==READ_TAG).
  - On an accepted beat, store bus_resp into the line slot selected by the beat counter, then increment the counter.
  - Beats with a non-matching tag are neither acked nor stored; they belong to the data side.
  - Beats arriving in REQ (before reqack) are ignored and not acked.
  - Gaps between beats are allowed and there is no timeout.
- Last beat: when the counter is LINE_BEATS-1 and a beat is accepted, go to DONE.
- DONE:
  - Lasts exactly one cycle with fill_done=1.
  - fill_line holds all beats; fill_line_addr = latched aligned address.
  - Return to IDLE next cycle.
- Output hold: fill_line and fill_line_addr hold their values until the next fill completes. They are not cleared on return to IDLE.
- fill_ready=0 in REQ/RESP/DONE. A fill_req asserted then is not accepted and must be held by the cache.
- Earliest restart: back-to-back fills are allowed. fill_req high in the cycle after DONE (IDLE) is accepted.
- Reset mid-operation: reset in any state returns to IDLE on that edge with all outputs at reset values. The partial line is discarded and bus_reqcyc drops immediately.
- Counter width: log2(LINE_BEATS) bits. The counter wraps to 0 only through DONE/IDLE and never overruns.

Test Plan:
- Basic fill:
  - Stimulus: fill_addr=0x1234, reqack 2 cycles after reqcyc, then 8 consecutive beats 0x100..0x107 with tag 0x1100.
  - Required: bus_req=0x1200 held throughout REQ; respack high on each beat; one fill_done pulse; fill_line[63:0]=0x100 and fill_line[511:448]=0x107; fill_line_addr=0x1200.
- Gapped beats:
  - Stimulus: same fill with 1–3 idle cycles between beats.
  - Required: same line contents; fill_done pulses 1 cycle after the 8th beat.
- Foreign tag:
  - Stimulus: during RESP, insert a beat with tag 0x0100 between beats 3 and 4.
  - Required: no respack for that beat; counter unchanged; line identical to the basic case.
- Back-to-back:
  - Stimulus: fill_req held high continuously, addresses 0x40 then 0x80.
  - Required: second request accepted the cycle after fill_done; second bus_req=0x80; fill_ready=0 during the first fill.
- Reset mid-fill:
  - Stimulus: assert reset after 4 beats, then run a new fill at 0x2000.
  - Required: bus_reqcyc/respack=0 and fill_ready=1 after the reset edge; no fill_done for the aborted fill; new fill completes correctly with fill_line_addr=0x2000.
- Request hold:
  - Stimulus: delay bus_reqack by 10 cycles.
  - Required: bus_reqcyc, bus_req and bus_reqtag constant for all 10 cycles; beats presented during REQ are not acked.
